// File: rtl/fifo_ctrl.sv
// FIFO control FSM: occupancy tracking, read/write enables and full/empty status.
// Optional sticky overflow/underflow flags are enabled by defining FIFO_CTRL_ERR_FLAGS_EN.
//
//   state      | meaning
//   -----------+--------------------------------------------
//   ST_EMPTY   | occupancy == 0, reads are refused
//   ST_PARTIAL | 0 < occupancy < MEMORY_DEPTH, both accepted
//   ST_FULL    | occupancy == MEMORY_DEPTH, writes are refused
module fifo_ctrl #(
  parameter int MEMORY_DEPTH = 4,
  parameter int ADDRESS_SIZE = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_req,
  input  logic                  rd_req,
  output logic                  cw_en,
  output logic                  cr_en,
  output logic                  full,
  output logic                  empty,
  output logic [ADDRESS_SIZE:0] fill_count,
  output logic                  overflow,
  output logic                  underflow
);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  localparam logic [ADDRESS_SIZE:0] DEPTH_C = (ADDRESS_SIZE+1)'(MEMORY_DEPTH);
  localparam logic [ADDRESS_SIZE:0] ONE_C   = (ADDRESS_SIZE+1)'(1);
  localparam logic [ADDRESS_SIZE:0] ZERO_C  = '0;

  state_t                state_q, state_d;
  logic [ADDRESS_SIZE:0] count_q, count_d;

  assign cw_en      = wr_req && (state_q != ST_FULL);
  assign cr_en      = rd_req && (state_q != ST_EMPTY);
  assign full       = (state_q == ST_FULL);
  assign empty      = (state_q == ST_EMPTY);
  assign fill_count = count_q;

  always_comb begin
    count_d = count_q;
    if (cw_en && !cr_en) begin
      count_d = count_q + ONE_C;
    end else if (cr_en && !cw_en) begin
      count_d = count_q - ONE_C;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        // A depth-1 FIFO goes straight between the end states.
        if (cw_en) state_d = (MEMORY_DEPTH == 1) ? ST_FULL : ST_PARTIAL;
      end
      ST_PARTIAL: begin
        if (count_d == ZERO_C) begin
          state_d = ST_EMPTY;
        end else if (count_d == DEPTH_C) begin
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (cr_en) state_d = (MEMORY_DEPTH == 1) ? ST_EMPTY : ST_PARTIAL;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      count_q <= ZERO_C;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

`ifdef FIFO_CTRL_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  assign overflow_d  = overflow_q  || (wr_req && (state_q == ST_FULL));
  assign underflow_d = underflow_q || (rd_req && (state_q == ST_EMPTY));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Randomized bench for fifo_ctrl against an occupancy-count reference model.
module tb_fifo_ctrl;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
`ifdef FIFO_CTRL_ERR_FLAGS_EN
  localparam bit FLAGS_EN = 1'b1;
`else
  localparam bit FLAGS_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_req = 1'b0;
  logic          rd_req = 1'b0;
  logic          cw_en, cr_en, full, empty, overflow, underflow;
  logic [AW:0]   fill_count;

  int n_chk = 0;
  int n_bad = 0;

  // reference model state
  int occ = 0;
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  fifo_ctrl #(.MEMORY_DEPTH(DEPTH), .ADDRESS_SIZE(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_req     (wr_req),
    .rd_req     (rd_req),
    .cw_en      (cw_en),
    .cr_en      (cr_en),
    .full       (full),
    .empty      (empty),
    .fill_count (fill_count),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, check outputs against the model, then
  // advance the model across the rising edge.
  task automatic step(input bit r, input bit w, input bit d);
    bit exp_cw, exp_cr;
    @(negedge clk);
    rst_n = r; wr_req = w; rd_req = d;
    #1;
    exp_cw = w && (occ < DEPTH);
    exp_cr = d && (occ > 0);
    chk("cw_en",      int'(cw_en),      int'(exp_cw));
    chk("cr_en",      int'(cr_en),      int'(exp_cr));
    chk("full",       int'(full),       int'(occ == DEPTH));
    chk("empty",      int'(empty),      int'(occ == 0));
    chk("fill_count", int'(fill_count), occ);
    chk("overflow",   int'(overflow),   int'(FLAGS_EN && m_ovf));
    chk("underflow",  int'(underflow),  int'(FLAGS_EN && m_unf));
    @(posedge clk);
    if (!r) begin
      occ = 0; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      if (w && occ == DEPTH) m_ovf = 1'b1;
      if (d && occ == 0)     m_unf = 1'b1;
      occ = occ + int'(exp_cw) - int'(exp_cr);
    end
  endtask

  initial begin
    @(posedge clk);
    step(0, 0, 0);
    step(0, 1, 1);

    for (int i = 0; i < 4; i++) step(1, 1, 0);
    step(1, 1, 0);
    chk("full_after_4wr", int'(full), 1);
    chk("fill_at_depth", int'(fill_count), DEPTH);

    for (int i = 0; i < 4; i++) step(1, 0, 1);
    step(1, 0, 1);
    chk("empty_after_4rd", int'(empty), 1);

    step(1, 0, 0);
    chk("unf_sticky", int'(underflow), int'(FLAGS_EN));

    step(0, 0, 0);
    step(1, 1, 0);
    step(1, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 1);
    chk("fill_hold_2", int'(fill_count), 2);

    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 1, 1);
    step(1, 0, 0);
    chk("fill_3_after_both", int'(fill_count), 3);
    chk("ovf_after_both", int'(overflow), int'(FLAGS_EN));

    step(1, 1, 1);
    step(1, 1, 1);
    step(0, 1, 0);
    step(1, 0, 0);
    chk("fill_0_after_rst", int'(fill_count), 0);

    // empty with both requests: write wins
    step(1, 1, 1);
    step(1, 0, 0);
    chk("fill_1_after_both_empty", int'(fill_count), 1);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 49) != 0), $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 The module SHALL provide parameter MEMORY_DEPTH, default 4, number of FIFO entries.
REQ-002 The module SHALL provide parameter ADDRESS_SIZE, default 2, pointer width; MEMORY_DEPTH <= 2**ADDRESS_SIZE.
REQ-003 The module SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 The module SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 The module SHALL have port wr_req  input  1  producer write request.
REQ-006 The module SHALL have port rd_req  input  1  consumer read request.
REQ-007 The module SHALL have port cw_en  output  1  write-address counter / memory write enable.
REQ-008 The module SHALL have port cr_en  output  1  read-address counter enable.
REQ-009 The module SHALL have port full  output  1  occupancy == MEMORY_DEPTH.
REQ-010 The module SHALL have port empty  output  1  occupancy == 0.
REQ-011 The module SHALL have port fill_count  output  ADDRESS_SIZE+1  current occupancy.
REQ-012 The module SHALL have port overflow  output  1  sticky: write requested while full.
REQ-013 The module SHALL have port underflow  output  1  sticky: read requested while empty.

Function
REQ-014 The FSM SHALL have states EMPTY, PARTIAL, FULL, plus a registered occupancy counter of width ADDRESS_SIZE+1.
REQ-015 cw_en SHALL be combinational: wr_req AND state != FULL; no dependence on rd_req.
REQ-016 cr_en SHALL be combinational: rd_req AND state != EMPTY; no dependence on wr_req.
REQ-017 Occupancy SHALL update each edge: +1 if cw_en & !cr_en, -1 if cr_en & !cw_en, hold otherwise (incl. both).
REQ-018 Transitions SHALL be: EMPTY->PARTIAL on accepted write; PARTIAL->EMPTY when occupancy goes 1->0; PARTIAL->FULL when occupancy goes MEMORY_DEPTH-1->MEMORY_DEPTH; FULL->PARTIAL on accepted read; else hold.
REQ-019 MEMORY_DEPTH==1 SHALL transition EMPTY<->FULL directly, never entering PARTIAL.
REQ-020 full and empty SHALL decode from the state register only (registered, one-cycle latency after the causing edge).
REQ-021 fill_count SHALL be the occupancy register, never exceeding MEMORY_DEPTH nor going below 0.
REQ-022 Full with wr_req and rd_req both high: read accepted, write rejected, overflow set, occupancy -> MEMORY_DEPTH-1.
REQ-023 Empty with wr_req and rd_req both high: write accepted, read rejected, underflow set, occupancy -> 1.
REQ-024 overflow/underflow SHALL set on the edge following the offending request and hold until reset.

Reset
REQ-025 On a rising clk edge with rst_n low: state EMPTY, occupancy 0, overflow 0, underflow 0.
REQ-026 During reset: empty=1, full=0, fill_count=0; cw_en/cr_en follow REQ-015/016 from reset state values.
REQ-027 Reset asserted mid-operation SHALL discard occupancy regardless of concurrent wr_req/rd_req; counters downstream are reset by the same rst_n.

Configuration
REQ-028 Macro FIFO_CTRL_ERR_FLAGS_EN defined: overflow/underflow SHALL behave per REQ-012/013/024.
REQ-029 Macro FIFO_CTRL_ERR_FLAGS_EN undefined: ports SHALL remain, tied constant 0, no flag registers synthesized; all other behaviour unchanged.

Verification
REQ-030 Reset then 4 writes, no reads (depth 4) -> fill_count 1,2,3,4; full=1 cycle after 4th write; cw_en=0 with wr_req high thereafter.
REQ-031 From full, 4 reads -> fill_count 3,2,1,0; empty=1 after 4th; cr_en=0 with rd_req high thereafter.
REQ-032 fill_count=2, wr_req=rd_req=1 for 5 cycles -> cw_en=cr_en=1 each cycle, fill_count stays 2, state PARTIAL.
REQ-033 Full, wr_req=rd_req=1 one cycle -> cw_en=0, cr_en=1, fill_count 3, overflow=1 (macro on) / 0 (macro off).
REQ-034 Empty, rd_req=1 one cycle -> cr_en=0, fill_count 0, underflow=1 (macro on), sticky until rst_n low.
REQ-035 fill_count=3, rst_n low one edge with wr_req=1 -> fill_count 0, empty=1, flags 0 next cycle.
